core_clk_ctrl: RTL
==================

# core_clk_ctrl

Clock-enable controller for the RISC-V core. Replaces the free-running divided clock with a single-cycle enable pulse on the board clock `clk1_s`. Supports halt, free-run at a programmable divisor, and single-step from a debounced push button, so the core can be run slowly or stepped instruction by instruction on the FPGA. It sits between the board clock/buttons and every core register's clock-enable; it also drives the visible slow-clock LED and a retired-tick counter.

## Interface
- `CNT_W`, 27: divisor/counter width.
- `DEFAULT_DIV`, 100000000: divisor loaded at reset, in `clk1_s` cycles per pulse.
- `DEB_CYCLES`, 1000000: cycles the synchronized button must be stable before it is accepted (≥2).
- `clk1_s`  in  1  board clock; all logic on its rising edge.
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `mode_i`  in  2  00 halt, 01 run, 10 step, 11 treated as halt.
- `div_wr_i`  in  1  load `div_i` into the divisor register this cycle.
- `div_i`  in  CNT_W  new divisor; 0 is stored as 1.
- `step_btn_i`  in  1  raw asynchronous push button, active-high.
- `core_ce_o`  out  1  core clock enable, registered, one-cycle pulse per tick.
- `slow_clk_o`  out  1  toggles on every `core_ce_o` pulse (LED).
- `tick_cnt_o`  out  32  count of issued pulses.
- `state_o`  out  2  current state: 00 HALT, 01 RUN, 10 STEP.

## Operation
- States: HALT, RUN, STEP. Next state is decoded from `mode_i` every cycle, so a mode change takes effect at the next edge. `mode_i` = 11 maps to HALT.
- HALT: no pulses; divide counter held at 0; button events discarded.
- RUN: divide counter `cnt` increments each cycle.
  - When `cnt == div_reg-1`: `cnt <= 0` and `core_ce_o <= 1`.
  - Otherwise `core_ce_o <= 0`.
  - Button events are ignored.
- Leaving RUN, or any divisor write, clears `cnt` to 0 on that edge.
- STEP: each accepted button press produces exactly one `core_ce_o` pulse. The pulse is registered on the edge after the press event is detected. Holding the button gives no further pulses; a new pulse needs a release and a re-press.
- Button path:
  - 2-flop synchronizer, then debounce counter.
  - Counter resets whenever the synchronized value equals the stable value.
  - Otherwise it increments; on reaching `DEB_CYCLES-1` the stable value takes the synchronized value and the counter clears.
  - Press event = stable 0→1.
  - The stable level is tracked in every state; only events in STEP produce pulses.
- Divisor write: `div_reg <= (div_i==0) ? 1 : div_i` on the write edge.
  - If a write coincides with `cnt == div_reg-1`, the write wins: no pulse, `cnt <= 0`.
- `div_reg == 1`: `core_ce_o` is high every cycle in RUN.
- Every pulse: `tick_cnt_o` increments (wraps 2^32-1 → 0) and `slow_clk_o` toggles on the same edge as `core_ce_o` rises.
- Reset values: `core_ce_o`=0, `slow_clk_o`=0, `tick_cnt_o`=0, `state_o`=00, `cnt`=0, `div_reg`=`DEFAULT_DIV`, synchronizer/stable/debounce = 0.
- Reset mid-pulse or mid-debounce aborts immediately, asynchronously; no pulse is issued after reset deassertion until the normal conditions recur.

## Timing
- Entering RUN at edge E (state becomes RUN, `cnt`=0): first `core_ce_o` high in the cycle after edge E+`div_reg`; period thereafter is `div_reg` cycles.
- `core_ce_o` width is always exactly one cycle, except in the continuous `div_reg`=1 case.
- Step latency from a clean button rise to `core_ce_o`: 2 sync + `DEB_CYCLES` debounce + 1 register cycles.
- `state_o` is registered and updates one edge after `mode_i` changes.
- Leaving RUN on the same edge a terminal count would fire: no pulse (state exit wins).

## Test plan
- `DEFAULT_DIV`=4, `DEB_CYCLES`=4; reset, `mode_i`=01 → `core_ce_o` pulses every 4 cycles, one cycle wide; after 5 pulses `tick_cnt_o`=5, `slow_clk_o`=1.
- In RUN, write `div_i`=0 → `div_reg`=1, `core_ce_o` high every cycle from the cycle after edge write+1; write coinciding with terminal count → no pulse that cycle.
- `mode_i`=10, button held high 20 cycles, released, pressed again → exactly 2 pulses, each 7 cycles after the press; 2-cycle glitches → no pulse.
- Press in RUN or HALT, then switch to STEP → no pulse; `mode_i`=11 → `state_o`=00, no pulses.
- Preload `tick_cnt_o` near wrap via forced run: 0xFFFFFFFF + 1 pulse → 0.
- Assert `rst_n` low mid-debounce and mid-RUN count → all outputs return to reset values immediately; no pulse within `div_reg` cycles of release.

Source files
------------

// File: rtl/core_clk_ctrl.sv
// core_clk_ctrl: clock-enable generator for the RISC-V core.
// The core is clocked from clk1_s and advances only on cycles where core_ce_o
// is high. Three modes are supported: HALT (no ticks), RUN (one tick every
// div_q cycles) and STEP (one tick per debounced press of step_btn_i).
// Every tick also toggles the LED output slow_clk_o and bumps the
// retired-tick counter.
module core_clk_ctrl #(
  parameter int CNT_W       = 27,
  parameter int DEFAULT_DIV = 100000000,
  parameter int DEB_CYCLES  = 1000000
) (
  input  logic             clk1_s,
  input  logic             rst_n,
  input  logic [1:0]       mode_i,
  input  logic             div_wr_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             step_btn_i,
  output logic             core_ce_o,
  output logic             slow_clk_o,
  output logic [31:0]      tick_cnt_o,
  output logic [1:0]       state_o
);

  localparam int DEB_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HALT = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10
  } state_e;

  state_e             state_q, state_d;

  // Button path: two-flop synchronizer, debounce counter, accepted level and
  // its one-cycle-delayed copy (the delayed copy gives the rising-edge event).
  logic               sync1_q, sync2_q;
  logic               stable_q, stable_d;
  logic               stable_dly_q;
  logic [DEB_W-1:0]   deb_q, deb_d;
  logic               press_evt;

  // Divider and tick bookkeeping.
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic               term_cnt;
  logic               ce_q, ce_d;
  logic               slow_q;
  logic [31:0]        tick_q;

  // ---------------------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk1_s or negedge rst_n) begin
    if (!rst_n) state_q <= S_HALT;
    else        state_q <= state_d;
  end

  // Next state follows mode_i directly; the reserved encoding 11 parks in HALT.
  always_comb begin
    state_d = S_HALT;
    unique case (mode_i)
      2'b01:   state_d = S_RUN;
      2'b10:   state_d = S_STEP;
      default: state_d = S_HALT;
    endcase
  end

  // State is exported as-is; encoding matches the external state_o coding.
  always_comb begin
    state_o = state_q;
  end

  // ---------------------------------------------------------------------------
  // Step button: synchronize, debounce, detect press
  // ---------------------------------------------------------------------------

  // Two-flop synchronizer for the raw asynchronous push button.
  always_ff @(posedge clk1_s or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= step_btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: the synchronized level must differ from the accepted level for
  // DEB_CYCLES consecutive cycles before it replaces it; any agreement restarts.
  always_comb begin
    stable_d = stable_q;
    deb_d    = '0;
    if (sync2_q != stable_q) begin
      if (deb_q == DEB_LAST) begin
        stable_d = sync2_q;
        deb_d    = '0;
      end else begin
        deb_d    = deb_q + DEB_W'(1);
      end
    end
  end

  // Debounce state registers; tracked in every mode so a press made outside
  // STEP is already "consumed" when STEP is entered.
  always_ff @(posedge clk1_s or negedge rst_n) begin
    if (!rst_n) begin
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      deb_q        <= '0;
    end else begin
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      deb_q        <= deb_d;
    end
  end

  assign press_evt = stable_q & ~stable_dly_q;

  // ---------------------------------------------------------------------------
  // Divider and tick generation
  // ---------------------------------------------------------------------------

  assign term_cnt = (cnt_q == (div_q - CNT_W'(1)));

  // Tick decision. In RUN the counter advances only while staying in RUN and
  // no divisor write is happening; a mode exit or a write both clear it and
  // suppress a coincident terminal-count tick. HALT/STEP keep the counter at 0.
  always_comb begin
    cnt_d = '0;
    ce_d  = 1'b0;
    div_d = div_q;
    if (div_wr_i) div_d = (div_i == '0) ? CNT_W'(1) : div_i;
    if (state_q == S_RUN && state_d == S_RUN && !div_wr_i) begin
      if (term_cnt) ce_d  = 1'b1;
      else          cnt_d = cnt_q + CNT_W'(1);
    end
    if (state_q == S_STEP && press_evt) ce_d = 1'b1;
  end

  // Divider counter and divisor register.
  always_ff @(posedge clk1_s or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      div_q <= CNT_W'(DEFAULT_DIV);
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  // Registered enable pulse.
  always_ff @(posedge clk1_s or negedge rst_n) begin
    if (!rst_n) ce_q <= 1'b0;
    else        ce_q <= ce_d;
  end

  // LED toggle and retired-tick counter move on the same edge as the pulse.
  always_ff @(posedge clk1_s or negedge rst_n) begin
    if (!rst_n) begin
      slow_q <= 1'b0;
      tick_q <= '0;
    end else if (ce_d) begin
      slow_q <= ~slow_q;
      tick_q <= tick_q + 32'd1;
    end
  end

  assign core_ce_o  = ce_q;
  assign slow_clk_o = slow_q;
  assign tick_cnt_o = tick_q;

endmodule
